// File: rtl/reg_file_pkg.sv
// Shared definitions for the integer register file with scoreboard.
//   RF_XLEN / RF_NREGS : default data width and register count
//   rf_state_t         : clear sequencer state (RF_CLEAR after reset, RF_RUN after)
package reg_file_pkg;

  localparam int unsigned RF_XLEN  = 32;
  localparam int unsigned RF_NREGS = 32;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_t;

endpackage

// File: rtl/reg_file_sb_scoreboard.sv
// Busy scoreboard: one pending-write bit per architectural register.
//   clk, rst          : clock, synchronous active-high reset (clears all bits)
//   set_en, set_addr  : mark a register busy (issue)
//   clr_en, clr_addr  : mark a register not busy (writeback)
//   rs1_addr/rs2_addr : lookup addresses
//   rs1_busy/rs2_busy : raw busy bits for the lookup addresses
module rf_scoreboard #(
  parameter int unsigned NREGS = 32,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          set_en,
  input  logic [AW-1:0] set_addr,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_addr,
  input  logic [AW-1:0] rs1_addr,
  input  logic [AW-1:0] rs2_addr,
  output logic          rs1_busy,
  output logic          rs2_busy
);

  logic [NREGS-1:0] busy;

  // The set is applied after the clear so that an issue and a writeback to
  // the same register on one edge leave the bit set (new producer wins).
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (clr_en) busy[clr_addr] <= 1'b0;
      if (set_en) busy[set_addr] <= 1'b1;
    end
  end

  assign rs1_busy = busy[rs1_addr];
  assign rs2_busy = busy[rs2_addr];

endmodule

// File: rtl/reg_file_sb.sv
// Integer register file with write-to-read bypass, busy scoreboard and a
// post-reset clear sequencer that zeroes every entry before going ready.
//   clk, rst            : clock, synchronous active-high reset
//   ready               : high once the clear sequence has finished
//   rs1_addr, rs2_addr  : read addresses
//   rs1_data, rs2_data  : combinational read data
//   rs1_busy, rs2_busy  : pending-write flags for the read registers
//   iss_en, iss_rd      : issue strobe, marks iss_rd busy
//   wr_en, wr_addr, wr_data : writeback port
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int unsigned XLEN     = RF_XLEN,
  parameter int unsigned NREGS    = RF_NREGS,
  parameter int unsigned AW       = $clog2(NREGS),
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic            clk,
  input  logic            rst,
  output logic            ready,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_rd,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data
);

  rf_state_t       state, state_nxt;
  logic [AW-1:0]   idx, idx_nxt;
  logic            clr_we;
  logic            run;
  logic [XLEN-1:0] regs [NREGS];

  logic            wr_eff;
  logic            iss_eff;
  logic            sb_busy1, sb_busy2;
  logic            zr1, zr2;
  logic            byp1, byp2;

  // Clear sequencer state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RF_CLEAR;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    clr_we    = 1'b0;
    if (state == RF_CLEAR) begin
      clr_we  = 1'b1;
      idx_nxt = idx + AW'(1);
      if (idx == AW'(NREGS - 1)) state_nxt = RF_RUN;
    end
  end

  assign run   = (state == RF_RUN);
  assign ready = run;

  // Writes and issues only take effect in RUN; register 0 absorbs them when
  // it is hardwired.
  assign wr_eff  = run && wr_en  && !((ZERO_REG != 0) && (wr_addr == '0));
  assign iss_eff = run && iss_en && !((ZERO_REG != 0) && (iss_rd  == '0));

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_we)      regs[idx]     <= '0;
      else if (wr_eff) regs[wr_addr] <= wr_data;
    end
  end

  rf_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_en   (iss_eff),
    .set_addr (iss_rd),
    .clr_en   (run && wr_en),
    .clr_addr (wr_addr),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_busy (sb_busy1),
    .rs2_busy (sb_busy2)
  );

  // Read muxes: hardwired zero, then same-cycle bypass, then stored state.
  assign zr1  = (ZERO_REG != 0) && (rs1_addr == '0);
  assign zr2  = (ZERO_REG != 0) && (rs2_addr == '0);
  assign byp1 = (BYPASS != 0) && wr_en && (wr_addr == rs1_addr);
  assign byp2 = (BYPASS != 0) && wr_en && (wr_addr == rs2_addr);

  always_comb begin
    rs1_data = '0;
    rs1_busy = 1'b0;
    if (run && !zr1) begin
      if (byp1) begin
        rs1_data = wr_data;
      end else begin
        rs1_data = regs[rs1_addr];
        rs1_busy = sb_busy1;
      end
    end
  end

  always_comb begin
    rs2_data = '0;
    rs2_busy = 1'b0;
    if (run && !zr2) begin
      if (byp2) begin
        rs2_data = wr_data;
      end else begin
        rs2_data = regs[rs2_addr];
        rs2_busy = sb_busy2;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned AW    = 5;
  localparam int NCFG = 3;  // 0: defaults, 1: ZERO_REG=0, 2: BYPASS=0

  logic            clk;
  logic            rst;
  logic [AW-1:0]   rs1_addr, rs2_addr;
  logic            iss_en;
  logic [AW-1:0]   iss_rd;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_data;

  logic            rdy [NCFG];
  logic [XLEN-1:0] d1  [NCFG];
  logic [XLEN-1:0] d2  [NCFG];
  logic            b1  [NCFG];
  logic            b2  [NCFG];

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    reg_file_sb #(
      .XLEN     (XLEN),
      .NREGS    (NREGS),
      .ZERO_REG ((g == 1) ? 0 : 1),
      .BYPASS   ((g == 2) ? 0 : 1)
    ) dut (
      .clk      (clk),
      .rst      (rst),
      .ready    (rdy[g]),
      .rs1_addr (rs1_addr),
      .rs2_addr (rs2_addr),
      .rs1_data (d1[g]),
      .rs2_data (d2[g]),
      .rs1_busy (b1[g]),
      .rs2_busy (b2[g]),
      .iss_en   (iss_en),
      .iss_rd   (iss_rd),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: architectural view per configuration
  logic [XLEN-1:0] m_regs [NCFG][NREGS];
  bit              m_busy [NCFG][NREGS];
  bit              m_valid;
  bit              m_clearing;
  int              m_cnt;

  function automatic bit cfg_zr(int g); return g != 1; endfunction
  function automatic bit cfg_bp(int g); return g != 2; endfunction

  task automatic check(string name, int g, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cfg%0d: got %0h expected %0h", name, g, act, exp);
    end
  endtask

  function automatic void exp_read(int g, logic [AW-1:0] a,
                                   output logic [XLEN-1:0] d, output bit b);
    if (m_clearing || (cfg_zr(g) && a == 0)) begin
      d = '0; b = 1'b0;
    end else if (cfg_bp(g) && wr_en && wr_addr == a) begin
      d = wr_data; b = 1'b0;
    end else begin
      d = m_regs[g][a]; b = m_busy[g][a];
    end
  endfunction

  task automatic check_model();
    logic [XLEN-1:0] ed;
    bit eb;
    if (!m_valid) return;
    for (int g = 0; g < NCFG; g++) begin
      check("ready", g, 64'(rdy[g]), 64'(!m_clearing));
      exp_read(g, rs1_addr, ed, eb);
      check("rs1_data", g, 64'(d1[g]), 64'(ed));
      check("rs1_busy", g, 64'(b1[g]), 64'(eb));
      exp_read(g, rs2_addr, ed, eb);
      check("rs2_data", g, 64'(d2[g]), 64'(ed));
      check("rs2_busy", g, 64'(b2[g]), 64'(eb));
    end
  endtask

  task automatic update_model();
    if (rst) begin
      m_valid    = 1'b1;
      m_clearing = 1'b1;
      m_cnt      = 0;
      for (int g = 0; g < NCFG; g++)
        for (int r = 0; r < int'(NREGS); r++) m_busy[g][r] = 1'b0;
    end else if (m_valid && m_clearing) begin
      for (int g = 0; g < NCFG; g++) m_regs[g][m_cnt] = '0;
      m_cnt++;
      if (m_cnt == int'(NREGS)) m_clearing = 1'b0;
    end else if (m_valid) begin
      for (int g = 0; g < NCFG; g++) begin
        if (wr_en) begin
          if (!(cfg_zr(g) && wr_addr == 0)) m_regs[g][wr_addr] = wr_data;
          m_busy[g][wr_addr] = 1'b0;
        end
        if (iss_en && !(cfg_zr(g) && iss_rd == 0)) m_busy[g][iss_rd] = 1'b1;
      end
    end
  endtask

  task automatic finish_cycle();
    check_model();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic cycle();
    @(negedge clk);
    finish_cycle();
  endtask

  task automatic idle_inputs();
    rst = 1'b0; iss_en = 1'b0; iss_rd = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
  endtask

  // Directed vectors; expectations are for the default configuration
  typedef struct {
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [XLEN-1:0] wr_data;
    logic            iss_en;
    logic [AW-1:0]   iss_rd;
    logic [AW-1:0]   a1, a2;
    logic [XLEN-1:0] e1, e2;
    logic            eb1, eb2;
  } vec_t;

  function automatic vec_t mk(logic we, int wa, logic [XLEN-1:0] wd, logic ie, int ir,
                              int a1, int a2, logic [XLEN-1:0] e1, logic [XLEN-1:0] e2,
                              logic eb1, logic eb2);
    vec_t v;
    v.wr_en = we; v.wr_addr = AW'(wa); v.wr_data = wd;
    v.iss_en = ie; v.iss_rd = AW'(ir);
    v.a1 = AW'(a1); v.a2 = AW'(a2);
    v.e1 = e1; v.e2 = e2; v.eb1 = eb1; v.eb2 = eb2;
    return v;
  endfunction

  vec_t tbl [15];

  initial begin
    tbl[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 5, 0, 32'hDEADBEEF, 32'h0, 0, 0);
    tbl[1]  = mk(1, 0, 32'h12345678, 0, 0, 5, 0, 32'hDEADBEEF, 32'h0, 0, 0);
    tbl[2]  = mk(0, 0, 32'h0,        0, 0, 5, 0, 32'hDEADBEEF, 32'h0, 0, 0);
    tbl[3]  = mk(1, 7, 32'hA5A5A5A5, 0, 0, 7, 7, 32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0);
    tbl[4]  = mk(0, 0, 32'h0,        1, 3, 3, 7, 32'h0, 32'hA5A5A5A5, 0, 0);
    tbl[5]  = mk(0, 0, 32'h0,        0, 0, 3, 3, 32'h0, 32'h0, 1, 1);
    tbl[6]  = mk(1, 3, 32'h33,       0, 0, 3, 5, 32'h33, 32'hDEADBEEF, 0, 0);
    tbl[7]  = mk(0, 0, 32'h0,        0, 0, 3, 5, 32'h33, 32'hDEADBEEF, 0, 0);
    tbl[8]  = mk(1, 3, 32'h44,       1, 3, 3, 3, 32'h44, 32'h44, 0, 0);
    tbl[9]  = mk(0, 0, 32'h0,        0, 0, 3, 3, 32'h44, 32'h44, 1, 1);
    tbl[10] = mk(0, 0, 32'h0,        1, 0, 0, 3, 32'h0, 32'h44, 0, 1);
    tbl[11] = mk(0, 0, 32'h0,        0, 0, 0, 7, 32'h0, 32'hA5A5A5A5, 0, 0);
    tbl[12] = mk(1, 9, 32'h55,       0, 0, 9, 9, 32'h55, 32'h55, 0, 0);
    tbl[13] = mk(0, 0, 32'h0,        1, 9, 9, 9, 32'h55, 32'h55, 0, 0);
    tbl[14] = mk(0, 0, 32'h0,        0, 0, 9, 9, 32'h55, 32'h55, 1, 1);

    m_valid = 1'b0; m_clearing = 1'b0; m_cnt = 0;
    idle_inputs();
    rs1_addr = '0; rs2_addr = '0;

    // Clear sequence: ready low for NREGS edges after rst, high from the last
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    wr_en = 1'b1; wr_addr = AW'(4); wr_data = 32'hFFFF0000;
    iss_en = 1'b1; iss_rd = AW'(4); rs1_addr = AW'(4); rs2_addr = AW'(1);
    @(negedge clk);
    check("ready_after_rst", 0, 64'(rdy[0]), 64'(0));
    check("clear_rd_zero", 0, 64'(d1[0]), 64'(0));
    finish_cycle();
    for (int i = 2; i <= int'(NREGS); i++) begin
      cycle();
      check("ready_count", 0, 64'(rdy[0]), 64'(i == int'(NREGS)));
    end
    idle_inputs();
    for (int a = 0; a < int'(NREGS); a++) begin
      rs1_addr = AW'(a); rs2_addr = AW'(int'(NREGS) - 1 - a);
      @(negedge clk);
      check("post_clear_zero", 0, 64'({b1[0], d1[0]}), 64'(0));
      finish_cycle();
    end

    // Directed table: write/read, x0, bypass, scoreboard set/clear/priority
    for (int i = 0; i < 15; i++) begin
      wr_en = tbl[i].wr_en; wr_addr = tbl[i].wr_addr; wr_data = tbl[i].wr_data;
      iss_en = tbl[i].iss_en; iss_rd = tbl[i].iss_rd;
      rs1_addr = tbl[i].a1; rs2_addr = tbl[i].a2;
      @(negedge clk);
      check($sformatf("tbl%0d_rs1_data", i), 0, 64'(d1[0]), 64'(tbl[i].e1));
      check($sformatf("tbl%0d_rs2_data", i), 0, 64'(d2[0]), 64'(tbl[i].e2));
      check($sformatf("tbl%0d_rs1_busy", i), 0, 64'(b1[0]), 64'(tbl[i].eb1));
      check($sformatf("tbl%0d_rs2_busy", i), 0, 64'(b2[0]), 64'(tbl[i].eb2));
      finish_cycle();
    end

    // Configuration-specific spot checks: ZERO_REG=0 keeps reg 0, BYPASS=0 is late
    idle_inputs();
    rs1_addr = AW'(0); rs2_addr = AW'(7);
    wr_en = 1'b1; wr_addr = AW'(7); wr_data = 32'h0BADF00D;
    @(negedge clk);
    check("nz_reg0", 1, 64'(d1[1]), 64'(32'h12345678));
    check("nobyp_old", 2, 64'(d2[2]), 64'(32'hA5A5A5A5));
    check("byp_new", 0, 64'(d2[0]), 64'(32'h0BADF00D));
    finish_cycle();
    idle_inputs();
    @(negedge clk);
    check("nobyp_next", 2, 64'(d2[2]), 64'(32'h0BADF00D));
    finish_cycle();

    // Mid-operation reset with reg 9 busy; writes during CLEAR are ignored
    rs1_addr = AW'(9); rs2_addr = AW'(9);
    @(negedge clk);
    check("r9_busy_before", 0, 64'({b1[0], d1[0]}), 64'({1'b1, 32'h55}));
    finish_cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    wr_en = 1'b1; wr_addr = AW'(9); wr_data = 32'h77;
    iss_en = 1'b1; iss_rd = AW'(9);
    for (int i = 1; i <= int'(NREGS); i++) begin
      cycle();
      check("mid_rst_ready", 0, 64'(rdy[0]), 64'(i == int'(NREGS)));
    end
    idle_inputs();
    @(negedge clk);
    check("r9_after_clear", 0, 64'({b1[0], d1[0]}), 64'(0));
    finish_cycle();

    // Randomized traffic against the model, with occasional resets
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      wr_en = $urandom_range(0, 1) != 0;
      iss_en = $urandom_range(0, 2) == 0;
      if ($urandom_range(0, 1) != 0) begin
        wr_addr = AW'($urandom_range(0, 3)); iss_rd = AW'($urandom_range(0, 3));
        rs1_addr = AW'($urandom_range(0, 3)); rs2_addr = AW'($urandom_range(0, 3));
      end else begin
        wr_addr = AW'($urandom); iss_rd = AW'($urandom);
        rs1_addr = AW'($urandom); rs2_addr = AW'($urandom);
      end
      wr_data = $urandom;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
Parametrised successor to the core's integer register file. It provides two combinational read ports, one writeback port with same-cycle write-to-read bypass, and a per-register busy scoreboard that decode uses for RAW hazard stalls. After reset, a clear sequencer zeroes every entry, so no X ever reaches the pipeline. It sits between decode (reads and issue marking) and writeback (writes).

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of architectural registers (power of two, at least 2)
AW, $clog2(NREGS), address width (derived; do not override)
ZERO_REG, 1, 1 = register 0 is hardwired to zero; 0 = register 0 is an ordinary register
BYPASS, 1, 1 = a same-cycle write is forwarded to the read data and busy outputs; 0 = no forwarding

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous active-high reset
ready  out  1  high once the clear sequence is done and normal operation is running
rs1_addr  in  AW  read port 1 address
rs2_addr  in  AW  read port 2 address
rs1_data  out  XLEN  read port 1 data (combinational)
rs2_data  out  XLEN  read port 2 data (combinational)
rs1_busy  out  1  read port 1 register has a pending write
rs2_busy  out  1  read port 2 register has a pending write
iss_en  in  1  issue strobe: mark iss_rd busy
iss_rd  in  AW  destination register of the issuing instruction
wr_en  in  1  writeback enable
wr_addr  in  AW  writeback address
wr_data  in  XLEN  writeback data

Behaviour:
- Reset and clear:
  - rst high at a posedge puts the block in state CLEAR, sets idx=0, clears every busy bit and drives ready=0.
  - rst has priority over every other input.
- CLEAR state:
  - Each posedge with rst low writes regs[idx]=0 and increments idx.
  - The edge that writes idx=NREGS-1 moves the block to RUN.
  - ready goes high exactly NREGS posedges after rst deasserts.
  - In CLEAR, wr_en and iss_en are ignored, rs*_data=0 and rs*_busy=0.
- RUN state:
  - ready=1.
  - The block leaves RUN only through rst. rst asserted mid-operation restarts CLEAR from idx=0 and discards in-flight busy state.
- Write:
  - On a posedge with wr_en=1, regs[wr_addr] is updated with wr_data.
  - The write is suppressed when ZERO_REG=1 and wr_addr=0.
  - The same posedge clears busy[wr_addr].
- Issue:
  - On a posedge with iss_en=1, busy[iss_rd] is set.
  - The set is suppressed when ZERO_REG=1 and iss_rd=0.
  - When iss and write target the same address on the same edge, busy ends set: the new producer wins.
- Read, for each port p:
  - With ZERO_REG=1 and rsp_addr=0: data=0, busy=0.
  - Otherwise, with BYPASS=1, wr_en=1 and wr_addr==rsp_addr (an effective write): data=wr_data and busy=0. The same-cycle iss is not reflected until the next cycle.
  - Otherwise: data=regs[rsp_addr], busy=busy[rsp_addr].
- Width rules:
  - Addresses are AW bits wide and not range-checked; NREGS is a power of two, so every address is valid.
  - Data is passed through unmodified.
- The register array and busy vector are only updated on posedge clk. There is no negedge logic.

Decomposition:
- Shared package reg_file_pkg holds:
  - default XLEN and NREGS constants;
  - the state enum rf_state_t {RF_CLEAR, RF_RUN}.
- One natural sub-module: rf_scoreboard, which holds the busy vector with its set/clear/priority logic and the busy lookup for both ports.
- The storage array, clear sequencer and bypass muxes stay in the top module.

Test Plan:
1. Clear sequence: pulse rst for 1 cycle with NREGS=32, then release -> ready=0 for 32 edges and 1 from the 32nd edge; reading every address then returns 0 with busy=0.
2. Write/read and x0: wr_en writes 0xDEADBEEF to reg 5, then 0x12345678 to reg 0 -> next cycle reg 5 reads 0xDEADBEEF and reg 0 reads 0; with ZERO_REG=0, reg 0 reads 0x12345678.
3. Bypass: same cycle, wr_en to reg 7 with 0xA5A5A5A5 and rs1_addr=rs2_addr=7 -> both ports read 0xA5A5A5A5 and busy=0 combinationally; with BYPASS=0 they read the old value until the next edge.
4. Scoreboard: iss_en to reg 3 -> rs1_busy=1 from the next cycle; a later wr_en to reg 3 -> busy=0 after that edge; iss_en and wr_en to reg 3 on the same edge -> busy stays 1.
5. Mid-operation reset: with reg 9 busy and holding 0x55, assert rst -> ready=0, busy cleared, and reg 9 reads 0 once ready returns after NREGS edges; a wr_en driven during CLEAR has no effect.
